// File: rtl/score_emitter_if.sv
// Event and award bundle between the playfield/line-clear logic and the score display.
// master: the score emitter (consumes events, drives awards); slave: its environment.
interface score_emitter_if;
  logic        clear_valid;
  logic [2:0]  clear_lines;
  logic        drop_valid;
  logic [4:0]  drop_cells;
  logic [15:0] scorewire;
  logic [3:0]  level;
  logic [9:0]  lines_total;
  logic        busy;
  logic        overflow;

  modport master (
    input  clear_valid, clear_lines, drop_valid, drop_cells,
    output scorewire, level, lines_total, busy, overflow
  );

  modport slave (
    output clear_valid, clear_lines, drop_valid, drop_cells,
    input  scorewire, level, lines_total, busy, overflow
  );
endinterface

// File: rtl/score_emitter.sv
// Turns line-clear and hard-drop events into single-cycle award pulses on scorewire,
// and owns the line total / level counters. Optional SCORE_BACK_TO_BACK_EN: consecutive 4-line clears score 1800.
module score_emitter #(
  parameter int FIFO_DEPTH      = 2,
  parameter int LEVEL_MAX       = 15,
  parameter int LINES_PER_LEVEL = 10,
  parameter int DROP_MULT       = 2
) (
  input  logic            clk_25_175,
  input  logic            reset,
  score_emitter_if.master sif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LIL_W = $clog2(LINES_PER_LEVEL + 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [10:0] base;
    logic [3:0]  lvl;
  } event_t;

  localparam int EVT_W = $bits(event_t);

  function automatic logic [10:0] base_of(input logic [2:0] lines);
    logic [10:0] b;
    case (lines)
      3'd1:    b = 11'd40;
      3'd2:    b = 11'd100;
      3'd3:    b = 11'd300;
      3'd4:    b = 11'd1200;
      default: b = 11'd0;
    endcase
    return b;
  endfunction

  function automatic logic [10:0] sat11(input logic [16:0] v);
    logic [10:0] r;
    if (v > 17'd2047) begin
      r = 11'd2047;
    end else begin
      r = v[10:0];
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [15:0]         acc_q, acc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [10:0]         base_cur_q, base_cur_d;
  event_t              fifo_q [FIFO_DEPTH];
  event_t              fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [10:0]         drop_acc_q, drop_acc_d;
  logic [9:0]          lines_total_q, lines_total_d;
  logic [LIL_W-1:0]    lil_q, lil_d;
  logic [3:0]          level_q, level_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic [15:0]         scorewire_q, scorewire_d;
`ifdef SCORE_BACK_TO_BACK_EN
  logic                prev4_q, prev4_d;
`endif

  logic                accept_s;
  logic                full_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_take_s;
  logic [10:0]         new_base_s;
  event_t              head_s;
  logic [10:0]         lines_sum_s;
  logic [LIL_W-1:0]    lil_sum_s;
  logic [16:0]         drop_contrib_s;

  // Event intake: FIFO push/pop, line/level counters, overflow and drop accumulation.
  always_comb begin
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    lines_total_d = lines_total_q;
    lil_d         = lil_q;
    level_d       = level_q;
    overflow_d    = overflow_q;
    drop_acc_d    = drop_acc_q;

    accept_s    = sif.clear_valid && (sif.clear_lines >= 3'd1) && (sif.clear_lines <= 3'd4);
    head_s      = fifo_q[rd_ptr_q];
    full_s      = (count_q == CNT_W'(FIFO_DEPTH));
    pop_s       = (state_q == S_IDLE) && (count_q != {CNT_W{1'b0}});
    push_s      = accept_s && (!full_s || pop_s);
    drop_take_s = (state_q == S_IDLE) && (count_q == {CNT_W{1'b0}}) && (drop_acc_q != 11'd0);

    new_base_s  = base_of(sif.clear_lines);
`ifdef SCORE_BACK_TO_BACK_EN
    prev4_d = prev4_q;
    if ((sif.clear_lines == 3'd4) && prev4_q) begin
      new_base_s = 11'd1800;
    end else begin
      new_base_s = base_of(sif.clear_lines);
    end
    if (accept_s) begin
      prev4_d = (sif.clear_lines == 3'd4);
    end else begin
      prev4_d = prev4_q;
    end
`endif

    if (push_s) begin
      fifo_d[wr_ptr_q] = {new_base_s, level_q};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A lost clear still counts toward lines and level.
    overflow_d  = overflow_q | (accept_s && full_s && !pop_s);
    lines_sum_s = 11'(lines_total_q) + 11'(sif.clear_lines);
    lil_sum_s   = lil_q + LIL_W'(sif.clear_lines);
    if (accept_s) begin
      lines_total_d = (lines_sum_s > 11'd999) ? 10'd999 : lines_sum_s[9:0];
      if (lil_sum_s >= LIL_W'(LINES_PER_LEVEL)) begin
        lil_d   = lil_sum_s - LIL_W'(LINES_PER_LEVEL);
        level_d = (level_q < 4'(LEVEL_MAX)) ? (level_q + 4'd1) : level_q;
      end else begin
        lil_d   = lil_sum_s;
        level_d = level_q;
      end
    end else begin
      lines_total_d = lines_total_q;
    end

    drop_contrib_s = 17'(sif.drop_cells) * 17'(DROP_MULT);
    if (drop_take_s) begin
      drop_acc_d = sif.drop_valid ? sat11(drop_contrib_s) : 11'd0;
    end else if (sif.drop_valid) begin
      drop_acc_d = sat11(17'(drop_acc_q) + drop_contrib_s);
    end else begin
      drop_acc_d = drop_acc_q;
    end
  end

  // Award sequencer: multiply by repeated addition, then emit one pulse.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    base_cur_d = base_cur_q;

    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          acc_d      = 16'd0;
          cnt_d      = head_s.lvl;
          base_cur_d = head_s.base;
          state_d    = S_MUL;
        end else if (drop_take_s) begin
          acc_d   = 16'(drop_acc_q);
          state_d = S_EMIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = acc_q + 16'(base_cur_q);
        if (cnt_q == 4'd0) begin
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    scorewire_d = (state_d == S_EMIT) ? acc_d : 16'd0;
    busy_d      = (state_d != S_IDLE) || (count_d != {CNT_W{1'b0}}) || (drop_acc_d != 11'd0);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      acc_q         <= 16'd0;
      cnt_q         <= 4'd0;
      base_cur_q    <= 11'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {EVT_W{1'b0}};
      end
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      drop_acc_q    <= 11'd0;
      lines_total_q <= 10'd0;
      lil_q         <= {LIL_W{1'b0}};
      level_q       <= 4'd0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      scorewire_q   <= 16'd0;
`ifdef SCORE_BACK_TO_BACK_EN
      prev4_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      base_cur_q    <= base_cur_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drop_acc_q    <= drop_acc_d;
      lines_total_q <= lines_total_d;
      lil_q         <= lil_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      scorewire_q   <= scorewire_d;
`ifdef SCORE_BACK_TO_BACK_EN
      prev4_q       <= prev4_d;
`endif
    end
  end

  assign sif.scorewire   = scorewire_q;
  assign sif.level       = level_q;
  assign sif.lines_total = lines_total_q;
  assign sif.busy        = busy_q;
  assign sif.overflow    = overflow_q;

endmodule

// File: tb/tb_score_emitter.sv
// Self-checking bench for score_emitter: directed scenarios plus randomized events
// checked against a line-count/award model of the scoring rules.
module tb_score_emitter;
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  score_emitter_if sif();

  score_emitter dut (
    .clk_25_175 (clk),
    .reset      (reset_n),
    .sif        (sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: value, sample cycle, and whether the previous sample was also nonzero.
  int pv[$];
  int pc[$];
  bit pm[$];
  bit prev_nz = 1'b0;
  always @(negedge clk) begin
    if (sif.scorewire != 16'd0) begin
      pv.push_back(int'(sif.scorewire));
      pc.push_back(cyc);
      pm.push_back(prev_nz);
    end
    prev_nz = (sif.scorewire != 16'd0);
  end

  // Reference model: everything follows from the raw count of accepted lines.
  int m_raw   = 0;
  bit m_prev4 = 1'b0;

  function automatic int m_level();
    return ((m_raw / 10) > 15) ? 15 : (m_raw / 10);
  endfunction

  function automatic int m_lines();
    return (m_raw > 999) ? 999 : m_raw;
  endfunction

  function automatic int m_award(input int lines);
    int lvl;
    int base;
    if (lines < 1 || lines > 4) return 0;
    lvl = m_level();
    case (lines)
      1:       base = 40;
      2:       base = 100;
      3:       base = 300;
      default: base = 1200;
    endcase
`ifdef SCORE_BACK_TO_BACK_EN
    if (lines == 4 && m_prev4) base = 1800;
`endif
    m_prev4 = (lines == 4);
    m_raw   = m_raw + lines;
    return base * (lvl + 1);
  endfunction

  task automatic clear_pulses();
    pv.delete();
    pc.delete();
    pm.delete();
  endtask

  task automatic idle_inputs();
    sif.clear_valid = 1'b0;
    sif.clear_lines = 3'd0;
    sif.drop_valid  = 1'b0;
    sif.drop_cells  = 5'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    m_raw   = 0;
    m_prev4 = 1'b0;
    clear_pulses();
  endtask

  // Returns the index of the edge at which the strobe is sampled.
  task automatic pulse_clear(input int lines, output int acc);
    @(negedge clk);
    acc = cyc + 1;
    sif.clear_valid = 1'b1;
    sif.clear_lines = 3'(lines);
    @(negedge clk);
    sif.clear_valid = 1'b0;
  endtask

  task automatic pulse_drop(input int cells, output int acc);
    @(negedge clk);
    acc = cyc + 1;
    sif.drop_valid = 1'b1;
    sif.drop_cells = 5'(cells);
    @(negedge clk);
    sif.drop_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while (sif.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sif.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, sif.busy, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    sif.clear_valid = 1'b1;
    sif.clear_lines = 3'd4;
    sif.drop_valid  = 1'b1;
    sif.drop_cells  = 5'd31;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (sif.scorewire !== 16'd0)  begin errors++; $display("FAIL reset_scorewire: got %0d, required 0", sif.scorewire); end
    checks++; if (sif.level !== 4'd0)        begin errors++; $display("FAIL reset_level: got %0d, required 0", sif.level); end
    checks++; if (sif.lines_total !== 10'd0) begin errors++; $display("FAIL reset_lines: got %0d, required 0", sif.lines_total); end
    checks++; if (sif.busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b, required 0", sif.busy); end
    checks++; if (sif.overflow !== 1'b0)     begin errors++; $display("FAIL reset_overflow: got %b, required 0", sif.overflow); end
  endtask

  task automatic test_single_clear();
    int acc;
    do_reset();
    pulse_clear(1, acc);
    repeat (5) @(negedge clk);
    checks++; if (pv.size() !== 1) begin errors++; $display("FAIL single_count: got %0d pulses, required 1", pv.size()); end
    if (pv.size() >= 1) begin
      checks++; if (pv[0] !== 40)      begin errors++; $display("FAIL single_value: got %0d, required 40", pv[0]); end
      checks++; if (pc[0] !== acc + 2) begin errors++; $display("FAIL single_latency: pulse at cycle %0d, required %0d", pc[0], acc + 2); end
    end
    checks++; if (sif.lines_total !== 10'd1) begin errors++; $display("FAIL single_lines: got %0d, required 1", sif.lines_total); end
    checks++; if (sif.level !== 4'd0)        begin errors++; $display("FAIL single_level: got %0d, required 0", sif.level); end
    checks++; if (sif.busy !== 1'b0)         begin errors++; $display("FAIL single_busy: got %b, required 0", sif.busy); end
  endtask

  task automatic test_level_up();
    int acc;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pulse_clear(1, acc);
      repeat (9) @(negedge clk);
    end
    pulse_clear(4, acc);
    wait_idle(40, "level_up");
    checks++; if (pv.size() !== 11) begin errors++; $display("FAIL levelup_count: got %0d pulses, required 11", pv.size()); end
    if (pv.size() == 11) begin
      checks++; if (pv[9] !== 40)    begin errors++; $display("FAIL levelup_tenth: got %0d, required 40", pv[9]); end
      checks++; if (pv[10] !== 2400) begin errors++; $display("FAIL levelup_eleventh: got %0d, required 2400", pv[10]); end
      checks++; if (pc[10] !== acc + 3) begin errors++; $display("FAIL levelup_latency: pulse at %0d, required %0d", pc[10], acc + 3); end
    end
    checks++; if (sif.level !== 4'd1)         begin errors++; $display("FAIL levelup_level: got %0d, required 1", sif.level); end
    checks++; if (sif.lines_total !== 10'd14) begin errors++; $display("FAIL levelup_lines: got %0d, required 14", sif.lines_total); end
  endtask

  task automatic test_drop_during_mul();
    do_reset();
    @(negedge clk);
    sif.clear_valid = 1'b1; sif.clear_lines = 3'd1;
    @(negedge clk);
    sif.clear_valid = 1'b0; sif.drop_valid = 1'b1; sif.drop_cells = 5'd17;
    @(negedge clk);
    sif.drop_cells = 5'd5;
    @(negedge clk);
    idle_inputs();
    wait_idle(30, "drop_mul");
    checks++; if (pv.size() !== 2) begin errors++; $display("FAIL dropmul_count: got %0d pulses, required 2", pv.size()); end
    if (pv.size() == 2) begin
      checks++; if (pv[0] !== 40) begin errors++; $display("FAIL dropmul_first: got %0d, required 40", pv[0]); end
      checks++; if (pv[1] !== 44) begin errors++; $display("FAIL dropmul_second: got %0d, required 44", pv[1]); end
      checks++; if (pm[1] !== 1'b0) begin errors++; $display("FAIL dropmul_gap: pulses adjacent, required a zero cycle between"); end
    end
  endtask

  task automatic test_overflow();
    int acc;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      pulse_clear(4, acc);
      wait_idle(40, "ovf_setup");
    end
    clear_pulses();
    checks++; if (sif.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b, required 0", sif.overflow); end
    checks++; if (sif.level !== 4'd5)    begin errors++; $display("FAIL ovf_level: got %0d, required 5", sif.level); end
    pulse_clear(1, acc);
    sif.clear_valid = 1'b1; sif.clear_lines = 3'd1;
    repeat (3) @(negedge clk);
    idle_inputs();
    wait_idle(60, "ovf");
    checks++; if (pv.size() !== 3) begin errors++; $display("FAIL ovf_count: got %0d pulses, required 3", pv.size()); end
    for (int i = 0; i < pv.size(); i++) begin
      checks++; if (pv[i] !== 240) begin errors++; $display("FAIL ovf_value%0d: got %0d, required 240", i, pv[i]); end
    end
    checks++; if (sif.overflow !== 1'b1)      begin errors++; $display("FAIL ovf_flag: got %b, required 1", sif.overflow); end
    checks++; if (sif.lines_total !== 10'd56) begin errors++; $display("FAIL ovf_lines: got %0d, required 56", sif.lines_total); end
  endtask

  task automatic test_reset_mid_mul();
    int acc;
    do_reset();
    pulse_clear(4, acc);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (pv.size() !== 0)          begin errors++; $display("FAIL rstmul_pulse: got %0d pulses, required 0", pv.size()); end
    checks++; if (sif.lines_total !== 10'd0) begin errors++; $display("FAIL rstmul_lines: got %0d, required 0", sif.lines_total); end
    checks++; if (sif.busy !== 1'b0)         begin errors++; $display("FAIL rstmul_busy: got %b, required 0", sif.busy); end
    pulse_clear(1, acc);
    repeat (5) @(negedge clk);
    checks++; if (pv.size() !== 1 || pv[0] !== 40) begin errors++; $display("FAIL rstmul_next: got %0d pulses (first %0d), required one of 40", pv.size(), (pv.size() > 0) ? pv[0] : 0); end
  endtask

  task automatic test_back_to_back();
    int acc;
    int seq[5] = '{4, 4, 4, 2, 4};
`ifdef SCORE_BACK_TO_BACK_EN
    int exp[5] = '{1200, 1800, 1800, 200, 2400};
`else
    int exp[5] = '{1200, 1200, 1200, 200, 2400};
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse_clear(seq[i], acc);
      wait_idle(40, "b2b");
    end
    checks++; if (pv.size() !== 5) begin errors++; $display("FAIL b2b_count: got %0d pulses, required 5", pv.size()); end
    for (int i = 0; i < 5 && i < pv.size(); i++) begin
      checks++; if (pv[i] !== exp[i]) begin errors++; $display("FAIL b2b_award%0d: got %0d, required %0d", i, pv[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    int acc, lines, cells, lvl, aw, ecyc;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      clear_pulses();
      if ($urandom_range(0, 2) != 2) begin
        lines = $urandom_range(0, 7);
        lvl   = m_level();
        aw    = m_award(lines);
        ecyc  = 0;
        pulse_clear(lines, acc);
        ecyc  = acc + 2 + lvl;
      end else begin
        cells = $urandom_range(0, 31);
        aw    = cells * 2;
        pulse_drop(cells, acc);
        ecyc  = acc + 1;
      end
      repeat (20) @(negedge clk);
      checks++; if (pv.size() !== ((aw != 0) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_count: got %0d pulses, required %0d", n, pv.size(), (aw != 0) ? 1 : 0); end
      if (aw != 0 && pv.size() == 1) begin
        checks++; if (pv[0] !== aw)   begin errors++; $display("FAIL rand%0d_value: got %0d, required %0d", n, pv[0], aw); end
        checks++; if (pc[0] !== ecyc) begin errors++; $display("FAIL rand%0d_latency: pulse at %0d, required %0d", n, pc[0], ecyc); end
      end
      checks++; if (int'(sif.lines_total) !== m_lines()) begin errors++; $display("FAIL rand%0d_lines: got %0d, required %0d", n, sif.lines_total, m_lines()); end
      checks++; if (int'(sif.level) !== m_level())       begin errors++; $display("FAIL rand%0d_level: got %0d, required %0d", n, sif.level, m_level()); end
    end
  endtask

  task automatic test_drop_burst();
    int sum = 0;
    int got = 0;
    int cells;
    clear_pulses();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cells = $urandom_range(1, 31);
      sum   = sum + cells * 2;
      sif.drop_valid = 1'b1;
      sif.drop_cells = 5'(cells);
    end
    @(negedge clk);
    idle_inputs();
    wait_idle(40, "burst");
    foreach (pv[i]) got = got + pv[i];
    checks++; if (got !== sum) begin errors++; $display("FAIL burst_sum: got %0d, required %0d", got, sum); end
    foreach (pm[i]) begin
      checks++; if (pm[i] !== 1'b0) begin errors++; $display("FAIL burst_merge%0d: pulse adjacent to previous, required a gap", i); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      sif.clear_valid = 1'b1;
      sif.clear_lines = 3'd4;
      void'(m_award(4));
    end
    @(negedge clk);
    idle_inputs();
    wait_idle(80, "sat");
    checks++; if (int'(sif.lines_total) !== m_lines()) begin errors++; $display("FAIL sat_lines: got %0d, required %0d", sif.lines_total, m_lines()); end
    checks++; if (sif.level !== 4'd15)   begin errors++; $display("FAIL sat_level: got %0d, required 15", sif.level); end
    checks++; if (sif.overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b, required 1", sif.overflow); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_clear();
    test_level_up();
    test_drop_during_mul();
    test_overflow();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    test_drop_burst();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_emitter.md
Name: score_emitter

Overview:
- Producer side of the scorewire interface: converts game events (line clears, hard drops) into point awards.
- Emits each award as a single-cycle nonzero pulse on scorewire; the score display accumulates these pulses.
- Also owns the line total and level counters.
- Sits between the playfield/line-clear logic and the score display.

Parameters:
- FIFO_DEPTH, 2, number of pending line-clear events buffered (power of two).
- LEVEL_MAX, 15, level saturation value.
- LINES_PER_LEVEL, 10, cleared lines needed per level increment.
- DROP_MULT, 2, points per hard-drop cell.

Ports:
- clk_25_175  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- clear_valid  in  1  single-cycle strobe: a line clear occurred.
- clear_lines  in  3  lines cleared with the strobe; legal values 1..4.
- drop_valid  in  1  single-cycle strobe: a hard drop finished.
- drop_cells  in  5  cells fallen in the hard drop (0..31).
- scorewire  out  16  award pulse; nonzero for exactly one cycle per award, 0 otherwise.
- level  out  4  current level.
- lines_total  out  10  total lines cleared, saturating at 999.
- busy  out  1  high when FSM not IDLE, FIFO non-empty, or drop_acc nonzero.
- overflow  out  1  sticky; set when a clear event is lost.

Behaviour:
- Reset (reset==0 at edge): all outputs 0, FIFO empty, drop_acc 0, FSM IDLE. Applies mid-operation; an in-flight award is discarded and scorewire is 0 from the next cycle.
- Accept: clear_valid with clear_lines in 1..4 enqueues {base, level_at_accept}. Any other clear_lines value is ignored entirely (no enqueue, no counting).
- Base values: 1→40, 2→100, 3→300, 4→1200.
- Counters at accept (same edge as the enqueue):
  - lines_total += clear_lines, saturating at 999.
  - Internal lines_in_level += clear_lines. On reaching ≥ LINES_PER_LEVEL, subtract LINES_PER_LEVEL and increment level, saturating at LEVEL_MAX.
  - The queued event carries the level from before this update.
- FIFO full + accept: the event is dropped and overflow is set; the counters still update. If a pop happens in the same cycle, the push succeeds.
- drop_acc (11 bit): on drop_valid, drop_acc += drop_cells*DROP_MULT, saturating at 2047. If drop_valid arrives in the same cycle drop_acc is transferred out, drop_acc loads only the new contribution.
- FSM:
  - IDLE:
    - FIFO non-empty: pop head, acc←0, cnt←level_at_accept, go to MUL.
    - Else if drop_acc≠0: acc←drop_acc, drop_acc←0, go to EMIT.
    - Clears take priority over drops.
  - MUL: acc←acc+base each cycle. If cnt==0 go to EMIT, else cnt−1. This takes level+1 cycles and yields base*(level+1), max 1200*16 = 19200, which fits 16 bits.
  - EMIT: scorewire=acc for this cycle only, then go to IDLE. Awards are never merged; consecutive pulses are separated by at least one zero cycle.
- Latency: a clear accepted at edge t, with an empty FIFO and idle FSM, pulses at cycle t+3+L, where L is the level carried by the event. A drop arriving at an idle block with an empty FIFO pulses at t+2.
- scorewire is driven from a register and is 0 in every state except EMIT.

Optional Feature:
- Macro: SCORE_BACK_TO_BACK_EN.
- When defined: a 4-line clear accepted when the previous accepted legal clear was also 4 lines uses base 1800 instead of 1200. Max award 28800, still within 16 bits. The "previous was 4" flag:
  - is cleared by any accepted 1..3 line clear;
  - is cleared by reset;
  - is unaffected by drops.
- When undefined: base for 4 lines is always 1200; no flag logic is present.

Test Plan:
- Reset, level 0, clear_lines=1 pulse → scorewire=40 for exactly one cycle, 3 cycles after accept; lines_total=1; level=0; busy low afterwards.
- Ten single-line clears spaced 10 cycles apart, then clear_lines=4 → the tenth award is 40 and the eleventh is 1200*2=2400; level=1; lines_total=14.
- drop_valid with drop_cells=17, then 5 one cycle later, while a clear is in MUL → the clear award is emitted first, then one drop pulse of 44.
- Three clear_valid strobes on consecutive cycles with FSM busy at level 5 (FIFO_DEPTH=2) → two awards emitted, overflow=1, lines_total counts all three.
- Reset asserted during MUL, then released → scorewire never pulses for that event; all outputs 0; next clear at level 0 gives 40.
- With SCORE_BACK_TO_BACK_EN defined: three consecutive 4-line clears at level 0 → awards 1200, 1800, 1800. Then a 2-line clear followed by a 4-line clear at level 1 → 200, then 2400.
